// File: rtl/fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_if
// Purpose : bundles the instruction-memory read port and the fetch->decode
//           handshake of the fetch controller.
// Signals :
//   imem_req     fetch -> mem   one-cycle read request
//   imem_addr    fetch -> mem   read address, valid while imem_req=1
//   imem_rvalid  mem -> fetch   read data valid (1+ cycles after imem_req)
//   imem_rdata   mem -> fetch   read data
//   if_valid     fetch -> decode  held instruction offered
//   if_instr     fetch -> decode  held instruction
//   if_pc        fetch -> decode  address of if_instr
//   id_ready     decode -> fetch  decode accepts this cycle
// Modports: master = fetch controller side, slave = memory/decode side.
// -----------------------------------------------------------------------------
interface fetch_ctrl_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 32
) ();
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic               id_ready;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_rvalid, imem_rdata, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_rvalid, imem_rdata, id_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Purpose : single-outstanding instruction fetch controller. Issues one read
//           per instruction, holds the returned word for decode until it is
//           accepted, follows redirects (discarding in-flight data) and stops
//           permanently after retiring a HALT (top nibble 4'hF) until reset.
// Ports   :
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   start          one-cycle pulse, begins fetching from pc (IDLE only)
//   bus            fetch_ctrl_if.master (imem read port + decode handshake)
//   redirect_valid branch/flush request
//   redirect_pc    new fetch address
//   halted         HALT instruction retired
//   fetch_cnt      accepted-instruction count (saturating)
//   stall_cnt      decode-stall cycle count (saturating)
// Config  : define FETCH_CTRL_PERF_CNT_EN to build the performance counters;
//           otherwise fetch_cnt/stall_cnt are constant 0 with no flops.
// -----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  fetch_ctrl_if.master      bus,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted,
  output logic [15:0]       fetch_cnt,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    HOLD   = 3'd3,
    DRAIN  = 3'd4,
    HALTED = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_pc_nxt;
  logic [INSTR_W-1:0] r_if_instr;
  logic [ADDR_W-1:0]  r_if_pc;
  logic               w_capture;
  logic               w_is_halt;

  assign w_is_halt = (r_if_instr[INSTR_W-1 -: 4] == 4'hF);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pc       <= '0;
      r_if_instr <= '0;
      r_if_pc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_capture) begin
        r_if_instr <= bus.imem_rdata;
        r_if_pc    <= r_pc;
      end
    end
  end

  // Next-state, pc update and outputs
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_capture     = 1'b0;
    bus.imem_req  = (r_state == REQ);
    bus.imem_addr = (r_state == REQ) ? r_pc : '0;
    bus.if_valid  = (r_state == HOLD);
    bus.if_instr  = r_if_instr;
    bus.if_pc     = r_if_pc;
    halted        = (r_state == HALTED);

    case (r_state)
      IDLE: begin
        if (redirect_valid) w_pc_nxt = redirect_pc;
        if (start)          w_state_nxt = REQ;
      end
      REQ: begin
        // A redirect here still leaves this cycle's request in flight, so
        // its data must be drained unless it is already returning.
        if (redirect_valid) begin
          w_pc_nxt    = redirect_pc;
          w_state_nxt = bus.imem_rvalid ? REQ : DRAIN;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          w_pc_nxt    = redirect_pc;
          w_state_nxt = bus.imem_rvalid ? REQ : DRAIN;
        end else if (bus.imem_rvalid) begin
          w_capture   = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        // Redirect wins over id_ready: the held word is dropped.
        if (redirect_valid) begin
          w_pc_nxt    = redirect_pc;
          w_state_nxt = REQ;
        end else if (bus.id_ready) begin
          w_pc_nxt    = r_pc + 1'b1;
          w_state_nxt = w_is_halt ? HALTED : REQ;
        end
      end
      DRAIN: begin
        if (redirect_valid)  w_pc_nxt = redirect_pc;
        if (bus.imem_rvalid) w_state_nxt = REQ;
      end
      HALTED: begin
        w_state_nxt = HALTED;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

`ifdef FETCH_CTRL_PERF_CNT_EN
  logic        w_xfer;
  logic        w_stall;
  logic [15:0] r_fetch_cnt;
  logic [15:0] r_stall_cnt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_xfer  = (r_state == HOLD) &&  bus.id_ready && !redirect_valid;
  assign w_stall = (r_state == HOLD) && !bus.id_ready && !redirect_valid;

  // Performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_cnt <= 16'd0;
      r_stall_cnt <= 16'd0;
    end else begin
      if (w_xfer)  r_fetch_cnt <= sat_inc(r_fetch_cnt);
      if (w_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign stall_cnt = r_stall_cnt;
`else
  assign fetch_cnt = 16'd0;
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Self-checking bench for fetch_ctrl: a memory responder with programmable
// latency, and a reference model that tracks the architectural fetch pc
// (start/redirect/accept rules) and the expected counter values.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        halted;
  logic [15:0] fetch_cnt;
  logic [15:0] stall_cnt;

  fetch_ctrl_if #(.ADDR_W(8), .INSTR_W(32)) bus ();

  fetch_ctrl #(.ADDR_W(8), .INSTR_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .fetch_cnt      (fetch_cnt),
    .stall_cnt      (stall_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] mem [256];
  int          lat = 1;
  int          m_cnt = 0;
  logic [7:0]  m_raddr;

  // reference model state
  logic [7:0]  m_pc;
  logic [15:0] m_fetch;
  logic [15:0] m_stall;
  logic        m_halted;

  logic [7:0]  req_addr_q[$];
  int          req_cyc_q[$];
  logic [7:0]  xo_pc_q[$];
  logic [7:0]  xe_pc_q[$];
  logic [31:0] xo_i_q[$];
  logic [31:0] xe_i_q[$];

  // memory responder: one read, returns lat cycles after the request cycle
  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
      if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = mem[m_raddr];
        end
      end
      if (bus.imem_req === 1'b1) begin
        m_cnt   = lat;
        m_raddr = bus.imem_addr;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [15:0] exp_fc();
`ifdef FETCH_CTRL_PERF_CNT_EN
    return m_fetch;
`else
    return 16'd0;
`endif
  endfunction

  function automatic logic [15:0] exp_sc();
`ifdef FETCH_CTRL_PERF_CNT_EN
    return m_stall;
`else
    return 16'd0;
`endif
  endfunction

  // advance one clock, updating the reference model from the inputs applied
  task automatic cycle();
    logic v, rdy, red;
    logic [7:0]  rpc;
    logic [31:0] ei;
    v   = bus.if_valid;
    rdy = bus.id_ready;
    red = redirect_valid;
    rpc = redirect_pc;
    if (bus.imem_req === 1'b1) begin
      req_addr_q.push_back(bus.imem_addr);
      req_cyc_q.push_back(cyc);
    end
    if (reset) begin
      m_pc = 8'd0; m_fetch = 16'd0; m_stall = 16'd0; m_halted = 1'b0;
    end else if (!m_halted) begin
      if (v === 1'b1 && rdy && !red) begin
        ei = mem[m_pc];
        xo_pc_q.push_back(bus.if_pc);
        xo_i_q.push_back(bus.if_instr);
        xe_pc_q.push_back(m_pc);
        xe_i_q.push_back(ei);
        m_pc    = m_pc + 8'd1;
        m_fetch = sat16(m_fetch);
        if (ei[31:28] == 4'hF) m_halted = 1'b1;
      end else if (v === 1'b1 && !rdy && !red) begin
        m_stall = sat16(m_stall);
      end
      if (red) m_pc = rpc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_q();
    req_addr_q.delete(); req_cyc_q.delete();
    xo_pc_q.delete(); xe_pc_q.delete(); xo_i_q.delete(); xe_i_q.delete();
  endtask

  task automatic do_reset();
    start = 0; redirect_valid = 0; bus.id_ready = 0;
    reset = 1;
    repeat (2) cycle();
    reset = 0;
    repeat (5) cycle();
    clear_q();
  endtask

  task automatic test_reset();
    start = 0; redirect_valid = 0; redirect_pc = 8'h00; bus.id_ready = 1;
    reset = 1;
    repeat (2) cycle();
    checks += 8;
    if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL reset_if_valid got=%b exp=0", bus.if_valid); end
    if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL reset_imem_req got=%b exp=0", bus.imem_req); end
    if (bus.imem_addr !== 8'h00) begin failures++; $display("FAIL reset_imem_addr got=%h exp=00", bus.imem_addr); end
    if (bus.if_pc !== 8'h00) begin failures++; $display("FAIL reset_if_pc got=%h exp=00", bus.if_pc); end
    if (bus.if_instr !== 32'h0) begin failures++; $display("FAIL reset_if_instr got=%h exp=0", bus.if_instr); end
    if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
    if (fetch_cnt !== 16'd0) begin failures++; $display("FAIL reset_fetch_cnt got=%0d exp=0", fetch_cnt); end
    if (stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
    reset = 0;
    cycle();
    clear_q();
  endtask

  task automatic test_sequential();
    do_reset();
    lat = 1; bus.id_ready = 1;
    start = 1; cycle(); start = 0;
    repeat (9) cycle();
    checks++;
    if (req_addr_q.size() < 3 || xo_pc_q.size() < 3) begin
      failures++;
      $display("FAIL seq_count reqs=%0d xfers=%0d exp>=3", req_addr_q.size(), xo_pc_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks += 3;
        if (req_addr_q[k] !== 8'(k)) begin failures++; $display("FAIL seq_addr[%0d] got=%h exp=%h", k, req_addr_q[k], 8'(k)); end
        if (xo_pc_q[k] !== 8'(k)) begin failures++; $display("FAIL seq_if_pc[%0d] got=%h exp=%h", k, xo_pc_q[k], 8'(k)); end
        if (xo_i_q[k] !== mem[k]) begin failures++; $display("FAIL seq_instr[%0d] got=%h exp=%h", k, xo_i_q[k], mem[k]); end
      end
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (req_cyc_q[k] - req_cyc_q[k-1] != 3) begin
          failures++;
          $display("FAIL seq_spacing[%0d] got=%0d exp=3", k, req_cyc_q[k] - req_cyc_q[k-1]);
        end
      end
    end
    checks++;
    if (fetch_cnt !== exp_fc()) begin failures++; $display("FAIL seq_fetch_cnt got=%0d exp=%0d", fetch_cnt, exp_fc()); end
  endtask

  task automatic test_stall();
    logic [7:0]  pc0;
    logic [31:0] i0;
    logic [15:0] exp5;
`ifdef FETCH_CTRL_PERF_CNT_EN
    exp5 = 16'd5;
`else
    exp5 = 16'd0;
`endif
    do_reset();
    lat = 2; bus.id_ready = 0;
    start = 1; cycle(); start = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.if_valid === 1'b1) break;
      cycle();
    end
    checks++;
    if (bus.if_valid !== 1'b1) begin failures++; $display("FAIL stall_reach_hold got=%b exp=1", bus.if_valid); end
    pc0 = bus.if_pc; i0 = bus.if_instr;
    repeat (5) begin
      cycle();
      checks += 4;
      if (bus.if_valid !== 1'b1) begin failures++; $display("FAIL stall_if_valid got=%b exp=1", bus.if_valid); end
      if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL stall_imem_req got=%b exp=0", bus.imem_req); end
      if (bus.if_pc !== pc0) begin failures++; $display("FAIL stall_if_pc got=%h exp=%h", bus.if_pc, pc0); end
      if (bus.if_instr !== i0) begin failures++; $display("FAIL stall_if_instr got=%h exp=%h", bus.if_instr, i0); end
    end
    checks++;
    if (stall_cnt !== exp5) begin failures++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt, exp5); end
    bus.id_ready = 1;
    cycle();
    bus.id_ready = 0;
    checks += 3;
    if (xo_pc_q.size() != 1) begin
      failures++; $display("FAIL stall_xfer_count got=%0d exp=1", xo_pc_q.size());
    end else if (xo_pc_q[0] !== 8'h00 || xo_i_q[0] !== mem[0]) begin
      failures++; $display("FAIL stall_xfer got=%h/%h exp=00/%h", xo_pc_q[0], xo_i_q[0], mem[0]);
    end
    if (fetch_cnt !== exp_fc()) begin failures++; $display("FAIL stall_fetch_cnt got=%0d exp=%0d", fetch_cnt, exp_fc()); end
    if (stall_cnt !== exp_sc()) begin failures++; $display("FAIL stall_cnt_after got=%0d exp=%0d", stall_cnt, exp_sc()); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    lat = 3; bus.id_ready = 1;
    start = 1; cycle(); start = 0;
    cycle();
    redirect_valid = 1; redirect_pc = 8'h40;
    cycle();
    redirect_valid = 0;
    for (int k = 0; k < 20; k++) begin
      if (req_addr_q.size() >= 2) break;
      cycle();
    end
    checks += 3;
    if (req_addr_q.size() < 2) begin
      failures++; $display("FAIL rdw_second_req got=%0d reqs exp=2", req_addr_q.size());
    end else if (req_addr_q[1] !== 8'h40) begin
      failures++; $display("FAIL rdw_addr got=%h exp=40", req_addr_q[1]);
    end
    if (xo_pc_q.size() != 0) begin failures++; $display("FAIL rdw_stale_xfer got=%0d exp=0", xo_pc_q.size()); end
    if (fetch_cnt !== 16'd0) begin failures++; $display("FAIL rdw_fetch_cnt got=%0d exp=0", fetch_cnt); end
    for (int k = 0; k < 20; k++) begin
      if (xo_pc_q.size() >= 1) break;
      cycle();
    end
    checks++;
    if (xo_pc_q.size() < 1) begin
      failures++; $display("FAIL rdw_xfer got=none exp=pc40");
    end else if (xo_pc_q[0] !== 8'h40 || xo_i_q[0] !== mem[8'h40]) begin
      failures++; $display("FAIL rdw_xfer got=%h/%h exp=40/%h", xo_pc_q[0], xo_i_q[0], mem[8'h40]);
    end
  endtask

  task automatic test_redirect_hold();
    do_reset();
    lat = 1; bus.id_ready = 0;
    // start and redirect together: fetch begins at the redirect target
    start = 1; redirect_valid = 1; redirect_pc = 8'h05;
    cycle();
    start = 0; redirect_valid = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.if_valid === 1'b1) break;
      cycle();
    end
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 8'h05) begin
      failures++; $display("FAIL rdh_hold got=%b/%h exp=1/05", bus.if_valid, bus.if_pc);
    end
    clear_q();
    bus.id_ready = 1; redirect_valid = 1; redirect_pc = 8'h20;
    cycle();
    bus.id_ready = 0; redirect_valid = 0;
    checks += 4;
    if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL rdh_if_valid got=%b exp=0", bus.if_valid); end
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h20) begin
      failures++; $display("FAIL rdh_req got=%b/%h exp=1/20", bus.imem_req, bus.imem_addr);
    end
    if (xo_pc_q.size() != 0) begin failures++; $display("FAIL rdh_xfer got=%0d exp=0", xo_pc_q.size()); end
    if (fetch_cnt !== 16'd0) begin failures++; $display("FAIL rdh_fetch_cnt got=%0d exp=0", fetch_cnt); end
  endtask

  task automatic test_wrap();
    do_reset();
    lat = 2; bus.id_ready = 1;
    redirect_valid = 1; redirect_pc = 8'hFF;
    cycle();
    redirect_valid = 0;
    checks++;
    if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL wrap_idle_redirect got=%b exp=0", bus.imem_req); end
    start = 1; cycle(); start = 0;
    for (int k = 0; k < 20; k++) begin
      if (req_addr_q.size() >= 2) break;
      cycle();
    end
    checks += 2;
    if (req_addr_q.size() < 2) begin
      failures++; $display("FAIL wrap_reqs got=%0d exp=2", req_addr_q.size());
    end else if (req_addr_q[0] !== 8'hFF || req_addr_q[1] !== 8'h00) begin
      failures++; $display("FAIL wrap_addr got=%h,%h exp=ff,00", req_addr_q[0], req_addr_q[1]);
    end
    if (xo_pc_q.size() < 1 || xo_pc_q[0] !== 8'hFF) begin
      failures++; $display("FAIL wrap_if_pc got=%0d xfers exp=pc ff", xo_pc_q.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    lat = 4; bus.id_ready = 1;
    start = 1; cycle(); start = 0;
    cycle();
    reset = 1; cycle(); reset = 0;
    repeat (6) begin
      cycle();
      checks += 2;
      if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL rmid_if_valid got=%b exp=0", bus.if_valid); end
      if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL rmid_imem_req got=%b exp=0", bus.imem_req); end
    end
    checks++;
    if (bus.if_instr !== 32'h0) begin failures++; $display("FAIL rmid_if_instr got=%h exp=0", bus.if_instr); end
    clear_q();
    start = 1; cycle(); start = 0;
    for (int k = 0; k < 20; k++) begin
      if (xo_pc_q.size() >= 1) break;
      cycle();
    end
    checks++;
    if (xo_pc_q.size() < 1 || xo_pc_q[0] !== 8'h00 || xo_i_q[0] !== mem[0]) begin
      failures++; $display("FAIL rmid_refetch xfers=%0d exp=pc00 instr %h", xo_pc_q.size(), mem[0]);
    end
  endtask

  task automatic test_random();
    do_reset();
    lat = 1;
    redirect_valid = 1; redirect_pc = 8'($urandom); start = 1;
    cycle();
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 0) lat = int'($urandom_range(1, 4));
      start          = ($urandom_range(0, 19) == 0);
      bus.id_ready   = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = 8'($urandom);
      cycle();
    end
    start = 0; redirect_valid = 0; bus.id_ready = 0;
    cycle();
    checks++;
    if (xo_pc_q.size() < 50) begin failures++; $display("FAIL rand_xfer_count got=%0d exp>=50", xo_pc_q.size()); end
    for (int k = 0; k < xo_pc_q.size(); k++) begin
      checks++;
      if (xo_pc_q[k] !== xe_pc_q[k] || xo_i_q[k] !== xe_i_q[k]) begin
        failures++;
        $display("FAIL rand_xfer[%0d] got=%h/%h exp=%h/%h", k, xo_pc_q[k], xo_i_q[k], xe_pc_q[k], xe_i_q[k]);
      end
    end
    checks += 2;
    if (fetch_cnt !== exp_fc()) begin failures++; $display("FAIL rand_fetch_cnt got=%0d exp=%0d", fetch_cnt, exp_fc()); end
    if (stall_cnt !== exp_sc()) begin failures++; $display("FAIL rand_stall_cnt got=%0d exp=%0d", stall_cnt, exp_sc()); end
  endtask

  task automatic test_halt();
    logic [31:0] saved;
    do_reset();
    saved = mem[8'h80];
    mem[8'h80] = 32'hF000_0000;
    lat = 1; bus.id_ready = 1;
    start = 1; redirect_valid = 1; redirect_pc = 8'h80;
    cycle();
    start = 0; redirect_valid = 0;
    for (int k = 0; k < 20; k++) begin
      if (xo_pc_q.size() >= 1) break;
      cycle();
    end
    checks += 4;
    if (halted !== 1'b1) begin failures++; $display("FAIL halt_halted got=%b exp=1", halted); end
    if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL halt_if_valid got=%b exp=0", bus.if_valid); end
    if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL halt_imem_req got=%b exp=0", bus.imem_req); end
    if (fetch_cnt !== exp_fc()) begin failures++; $display("FAIL halt_fetch_cnt got=%0d exp=%0d", fetch_cnt, exp_fc()); end
    repeat (4) begin
      start = 1; redirect_valid = 1; redirect_pc = 8'($urandom);
      cycle();
      checks += 2;
      if (halted !== 1'b1) begin failures++; $display("FAIL halt_sticky got=%b exp=1", halted); end
      if (bus.imem_req !== 1'b0 || bus.if_valid !== 1'b0) begin
        failures++; $display("FAIL halt_quiet req=%b valid=%b exp=0/0", bus.imem_req, bus.if_valid);
      end
    end
    start = 0; redirect_valid = 0;
    reset = 1; cycle(); reset = 0;
    checks += 2;
    if (halted !== 1'b0) begin failures++; $display("FAIL halt_reset got=%b exp=0", halted); end
    if (bus.if_pc !== 8'h00) begin failures++; $display("FAIL halt_reset_if_pc got=%h exp=00", bus.if_pc); end
    start = 1; cycle(); start = 0;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin
      failures++; $display("FAIL halt_reset_pc req=%b addr=%h exp=1/00", bus.imem_req, bus.imem_addr);
    end
    mem[8'h80] = saved;
  endtask

  initial begin
    reset = 1; start = 0; redirect_valid = 0; redirect_pc = 8'h00;
    bus.id_ready = 0;
    m_pc = 8'd0; m_fetch = 16'd0; m_stall = 16'd0; m_halted = 1'b0;
    // bit 28 cleared keeps every random word from being a HALT
    for (int i = 0; i < 256; i++) mem[i] = $urandom & 32'hEFFF_FFFF;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap();
    test_reset_mid();
    test_random();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
